// File: rtl/jump_pc_controller_pkg.sv
// Shared constants for the jump-group PC controller: condition codes, phase FSM
// encodings, PC increment and the strobe-collision helper.
package jump_pc_controller_pkg;

    // Condition select codes index into FLAGS = {V,N,Z,C}
    localparam logic [1:0] CC_SEL_C = 2'd0;
    localparam logic [1:0] CC_SEL_Z = 2'd1;
    localparam logic [1:0] CC_SEL_N = 2'd2;
    localparam logic [1:0] CC_SEL_V = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FET  = 2'd1;
    localparam logic [1:0] S_DEC  = 2'd2;
    localparam logic [1:0] S_EXE  = 2'd3;

    localparam int unsigned PC_INC = 32'd2;

    // JUMP_STATS_EN is undefined by default: no jump statistics counters.

    function automatic logic multi_hot(input logic [3:0] v);
        return |(v & (v - 4'd1));
    endfunction

endpackage

// File: rtl/jump_pc_controller_if.sv
// Decode/PC bus between the jump-group decoder side (master) and the PC
// controller (slave). Statistics counters exist only with JUMP_STATS_EN.
interface jump_pc_controller_if #(parameter int PC_WIDTH = 16);
    logic                FETCH;
    logic                DECODE;
    logic                EXECUTE;
    logic                COMMIT;
    logic                JMPX;
    logic                JRX;
    logic                CC_APPLYX;
    logic                CC_INVERTX;
    logic [1:0]          CC_SELECTX;
    logic [3:0]          FLAGS;
    logic [PC_WIDTH-1:0] JUMP_OPERAND;
    logic [PC_WIDTH-1:0] PC_OUT;
    logic [PC_WIDTH-1:0] LINK_DATA;
    logic                LINK_WEN;
    logic                TAKEN;
    logic                SEQ_ERR;
`ifdef JUMP_STATS_EN
    logic [15:0]         JUMP_TAKEN_CNT;
    logic [15:0]         JUMP_NOTTAKEN_CNT;

    modport master (
        output FETCH, DECODE, EXECUTE, COMMIT, JMPX, JRX, CC_APPLYX, CC_INVERTX,
               CC_SELECTX, FLAGS, JUMP_OPERAND,
        input  PC_OUT, LINK_DATA, LINK_WEN, TAKEN, SEQ_ERR,
               JUMP_TAKEN_CNT, JUMP_NOTTAKEN_CNT
    );
    modport slave (
        input  FETCH, DECODE, EXECUTE, COMMIT, JMPX, JRX, CC_APPLYX, CC_INVERTX,
               CC_SELECTX, FLAGS, JUMP_OPERAND,
        output PC_OUT, LINK_DATA, LINK_WEN, TAKEN, SEQ_ERR,
               JUMP_TAKEN_CNT, JUMP_NOTTAKEN_CNT
    );
`else
    modport master (
        output FETCH, DECODE, EXECUTE, COMMIT, JMPX, JRX, CC_APPLYX, CC_INVERTX,
               CC_SELECTX, FLAGS, JUMP_OPERAND,
        input  PC_OUT, LINK_DATA, LINK_WEN, TAKEN, SEQ_ERR
    );
    modport slave (
        input  FETCH, DECODE, EXECUTE, COMMIT, JMPX, JRX, CC_APPLYX, CC_INVERTX,
               CC_SELECTX, FLAGS, JUMP_OPERAND,
        output PC_OUT, LINK_DATA, LINK_WEN, TAKEN, SEQ_ERR
    );
`endif
endinterface

// File: rtl/jump_pc_controller_cond_eval.sv
// Combinational jump condition: selects one ALU flag, optionally inverts it, and
// qualifies the result with the jump-group and conditional controls.
module jump_cond_eval
    import jump_pc_controller_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [1:0] cc_select,
    input  logic       cc_invert,
    input  logic       cc_apply,
    input  logic       jmpx,
    output logic       take
);

    logic flag_s;

    // Flag selection
    always_comb begin
        flag_s = 1'b0;
        case (cc_select)
            CC_SEL_C: flag_s = flags[0];
            CC_SEL_Z: flag_s = flags[1];
            CC_SEL_N: flag_s = flags[2];
            CC_SEL_V: flag_s = flags[3];
            default:  flag_s = 1'b0;
        endcase
    end

    assign take = jmpx & (~cc_apply | (flag_s ^ cc_invert));

endmodule

// File: rtl/jump_pc_controller.sv
// Jump-group PC controller: phase FSM, PC register, link write and sticky
// sequencing error. Optional counters built when JUMP_STATS_EN is defined.
module jump_pc_controller
    import jump_pc_controller_pkg::*;
#(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b0}}
)(
    input  logic                 CLK,
    input  logic                 RESET,
    jump_pc_controller_if.slave  bus
);

    localparam logic [PC_WIDTH-1:0] INC = PC_WIDTH'(PC_INC);

    logic [1:0]          state_r, next_state_s;
    logic [PC_WIDTH-1:0] pc_r, link_data_r, operand_r;
    logic [PC_WIDTH-1:0] seq_s, rel_s, next_pc_s;
    logic                link_wen_r, taken_r, seq_err_r, jrx_r, jmpx_r;
    logic                bad_s, do_exe_s, do_commit_s, take_s;
    logic [3:0]          strobes_s;

    assign strobes_s = {bus.FETCH, bus.DECODE, bus.EXECUTE, bus.COMMIT};

    jump_cond_eval u_cond (
        .flags     (bus.FLAGS),
        .cc_select (bus.CC_SELECTX),
        .cc_invert (bus.CC_INVERTX),
        .cc_apply  (bus.CC_APPLYX),
        .jmpx      (bus.JMPX),
        .take      (take_s)
    );

    // Phase decode: illegal or colliding strobes are flagged and otherwise ignored
    always_comb begin
        next_state_s = state_r;
        bad_s        = 1'b0;
        do_exe_s     = 1'b0;
        do_commit_s  = 1'b0;
        if (multi_hot(strobes_s)) begin
            bad_s = 1'b1;
        end else if (bus.FETCH) begin
            if (state_r == S_IDLE || state_r == S_EXE) next_state_s = S_FET;
            else                                        bad_s = 1'b1;
        end else if (bus.DECODE) begin
            if (state_r == S_FET) next_state_s = S_DEC;
            else                  bad_s = 1'b1;
        end else if (bus.EXECUTE) begin
            if (state_r == S_DEC) begin
                next_state_s = S_EXE;
                do_exe_s     = 1'b1;
            end else begin
                bad_s = 1'b1;
            end
        end else if (bus.COMMIT) begin
            if (state_r == S_EXE) begin
                next_state_s = S_IDLE;
                do_commit_s  = 1'b1;
            end else begin
                bad_s = 1'b1;
            end
        end else begin
            next_state_s = state_r;
        end
    end

    assign seq_s = pc_r + INC;
    assign rel_s = seq_s + (operand_r << 1);

    // Commit target selection from the latched jump state
    always_comb begin
        next_pc_s = seq_s;
        if (!taken_r)   next_pc_s = seq_s;
        else if (jrx_r) next_pc_s = {rel_s[PC_WIDTH-1:1], 1'b0};
        else            next_pc_s = {operand_r[PC_WIDTH-1:1], 1'b0};
    end

    // Phase state and sticky sequencing error
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r   <= S_IDLE;
            seq_err_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            seq_err_r <= seq_err_r | bad_s;
        end
    end

    // EXECUTE-time latch so the decoder may move on before COMMIT
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            taken_r   <= 1'b0;
            jrx_r     <= 1'b0;
            jmpx_r    <= 1'b0;
            operand_r <= {PC_WIDTH{1'b0}};
        end else if (do_exe_s) begin
            taken_r   <= take_s;
            jrx_r     <= bus.JRX;
            jmpx_r    <= bus.JMPX;
            operand_r <= bus.JUMP_OPERAND;
        end else begin
            taken_r   <= taken_r;
        end
    end

    // PC and link register write, both only at COMMIT
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_r        <= RESET_VECTOR;
            link_data_r <= {PC_WIDTH{1'b0}};
            link_wen_r  <= 1'b0;
        end else begin
            if (do_commit_s) pc_r <= next_pc_s;
            if (do_commit_s && taken_r && !jrx_r) begin
                link_data_r <= seq_s;
                link_wen_r  <= 1'b1;
            end else begin
                link_wen_r  <= 1'b0;
            end
        end
    end

    assign bus.PC_OUT    = pc_r;
    assign bus.LINK_DATA = link_data_r;
    assign bus.LINK_WEN  = link_wen_r;
    assign bus.TAKEN     = taken_r;
    assign bus.SEQ_ERR   = seq_err_r;

`ifdef JUMP_STATS_EN
    logic [15:0] taken_cnt_r, nottaken_cnt_r;

    // Saturating jump statistics, counted at COMMIT of jump-group instructions
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            taken_cnt_r    <= 16'h0000;
            nottaken_cnt_r <= 16'h0000;
        end else if (do_commit_s && jmpx_r) begin
            if (taken_r && taken_cnt_r != 16'hFFFF)
                taken_cnt_r <= taken_cnt_r + 16'h0001;
            if (!taken_r && nottaken_cnt_r != 16'hFFFF)
                nottaken_cnt_r <= nottaken_cnt_r + 16'h0001;
        end else begin
            taken_cnt_r <= taken_cnt_r;
        end
    end

    assign bus.JUMP_TAKEN_CNT    = taken_cnt_r;
    assign bus.JUMP_NOTTAKEN_CNT = nottaken_cnt_r;
`else
    logic unused_s;
    assign unused_s = jmpx_r;
`endif

endmodule

// File: tb/tb_jump_pc_controller.sv
// Scoreboard bench for jump_pc_controller (RESET_VECTOR=16'h0100); expected commit
// results are queued when an instruction is driven and checked after COMMIT.
module tb_jump_pc_controller;

    localparam logic [15:0] RV = 16'h0100;

    typedef struct {
        logic [15:0] pc;
        logic        wen;
        logic [15:0] link;
        logic        taken;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];
    logic [15:0] model_pc;
    logic [15:0] model_link;
    int   model_tk_cnt;
    int   model_nt_cnt;

    jump_pc_controller_if #(.PC_WIDTH(16)) bus ();

    jump_pc_controller #(.PC_WIDTH(16), .RESET_VECTOR(RV)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        model_pc     = RV;
        model_link   = 16'h0000;
        model_tk_cnt = 0;
        model_nt_cnt = 0;
        sb_q.delete();
    endtask

    // One full FETCH/DECODE/EXECUTE/COMMIT instruction; rst_after hits reset
    // while LINK_WEN is (possibly) high instead of idling a cycle.
    task automatic run_instr(input logic jmpx, input logic jrx, input logic apply,
                             input logic inv, input logic [1:0] sel, input logic [3:0] flags,
                             input logic [15:0] op, input logic rst_after);
        exp_t e, got;
        logic tk;
        logic [15:0] seq;
        tk  = jmpx & (~apply | (flags[sel] ^ inv));
        seq = model_pc + 16'd2;
        e.taken = tk;
        e.wen   = tk & ~jrx;
        if (!tk)      e.pc = seq;
        else if (jrx) e.pc = (seq + {op[14:0], 1'b0}) & 16'hFFFE;
        else          e.pc = op & 16'hFFFE;
        if (e.wen) model_link = seq;
        e.link   = model_link;
        model_pc = e.pc;
        if (jmpx && tk)  model_tk_cnt++;
        if (jmpx && !tk) model_nt_cnt++;
        sb_q.push_back(e);

        bus.FETCH = 1'b1; step(); bus.FETCH = 1'b0;
        bus.DECODE = 1'b1; step(); bus.DECODE = 1'b0;
        bus.JMPX = jmpx; bus.JRX = jrx; bus.CC_APPLYX = apply; bus.CC_INVERTX = inv;
        bus.CC_SELECTX = sel; bus.FLAGS = flags; bus.JUMP_OPERAND = op;
        bus.EXECUTE = 1'b1; step(); bus.EXECUTE = 1'b0;
        check_val("pc_hold_exe", {16'h0, bus.PC_OUT}, {16'h0, seq - 16'd2});
        // Decoder moves on: the controller must rely on its own latches
        bus.JMPX = ~jmpx; bus.JRX = ~jrx; bus.FLAGS = ~flags; bus.CC_INVERTX = ~inv;
        bus.JUMP_OPERAND = 16'($urandom);
        bus.COMMIT = 1'b1; step(); bus.COMMIT = 1'b0;
        bus.JMPX = 1'b0;
        got = sb_q.pop_front();
        check_val("pc",        {16'h0, bus.PC_OUT},    {16'h0, got.pc});
        check_val("link_wen",  {31'h0, bus.LINK_WEN},  {31'h0, got.wen});
        check_val("link_data", {16'h0, bus.LINK_DATA}, {16'h0, got.link});
        check_val("taken",     {31'h0, bus.TAKEN},     {31'h0, got.taken});
        if (rst_after) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check_val("wen_async_drop", {31'h0, bus.LINK_WEN}, 32'h0);
            check_val("pc_async_rst",   {16'h0, bus.PC_OUT},   {16'h0, RV});
        end else begin
            step();
            check_val("wen_one_cycle", {31'h0, bus.LINK_WEN}, 32'h0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.FETCH = 1'b0; bus.DECODE = 1'b0; bus.EXECUTE = 1'b0; bus.COMMIT = 1'b0;
        bus.JMPX = 1'b0; bus.JRX = 1'b0; bus.CC_APPLYX = 1'b0; bus.CC_INVERTX = 1'b0;
        bus.CC_SELECTX = 2'd0; bus.FLAGS = 4'h0; bus.JUMP_OPERAND = 16'h0000;
        model_reset();
        #12;
        check_val("rst_pc",      {16'h0, bus.PC_OUT},    {16'h0, RV});
        check_val("rst_link",    {16'h0, bus.LINK_DATA}, 32'h0);
        check_val("rst_wen",     {31'h0, bus.LINK_WEN},  32'h0);
        check_val("rst_taken",   {31'h0, bus.TAKEN},     32'h0);
        check_val("rst_seq_err", {31'h0, bus.SEQ_ERR},   32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Sequential flow
        for (int i = 0; i < 3; i++) run_instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'($urandom), 1'b0);
        check_val("seq_3", {16'h0, bus.PC_OUT}, 32'h0106);

        // Absolute jumps with link
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h0200, 1'b0);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h1235, 1'b0);
        check_val("abs_pc",   {16'h0, bus.PC_OUT},    32'h1234);
        check_val("abs_link", {16'h0, bus.LINK_DATA}, 32'h0202);

        // Relative conditional on Z
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h0300, 1'b0);
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0010, 16'hFFFE, 1'b0);
        check_val("rel_z1", {16'h0, bus.PC_OUT}, 32'h02FE);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h0300, 1'b0);
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'b1101, 16'hFFFE, 1'b0);
        check_val("rel_z0", {16'h0, bus.PC_OUT}, 32'h0302);

        // Inverted carry condition, absolute
        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 16'h0500, 1'b0);
        check_val("inv_c1", {16'h0, bus.PC_OUT}, 32'h0304);
        run_instr(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 4'b1110, 16'h0500, 1'b0);
        check_val("inv_c0", {16'h0, bus.PC_OUT}, 32'h0500);
        // Remaining selects: N and V
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0100, 16'h0010, 1'b0);
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0111, 16'h0010, 1'b0);

        // Sequencing errors
        bus.DECODE = 1'b1; step(); bus.DECODE = 1'b0;
        check_val("err_dec_flag", {31'h0, bus.SEQ_ERR}, 32'h1);
        check_val("err_dec_pc",   {16'h0, bus.PC_OUT},  {16'h0, model_pc});
        bus.FETCH = 1'b1; bus.EXECUTE = 1'b1; step(); bus.FETCH = 1'b0; bus.EXECUTE = 1'b0;
        check_val("err_multi_pc", {16'h0, bus.PC_OUT},  {16'h0, model_pc});
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h0000, 1'b0);
        check_val("err_sticky",   {31'h0, bus.SEQ_ERR}, 32'h1);

        // Wrap-around cases
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'hFFFE, 1'b0);
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h1111, 1'b0);
        check_val("wrap_seq", {16'h0, bus.PC_OUT}, 32'h0000);
        run_instr(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 16'hFFF0, 1'b0);
        check_val("wrap_rel", {16'h0, bus.PC_OUT}, 32'hFFE2);

`ifdef JUMP_STATS_EN
        check_val("cnt_taken",    {16'h0, bus.JUMP_TAKEN_CNT},    32'(model_tk_cnt));
        check_val("cnt_nottaken", {16'h0, bus.JUMP_NOTTAKEN_CNT}, 32'(model_nt_cnt));
`endif

        // Reset while a taken absolute jump sits in S_EXE
        bus.FETCH = 1'b1; step(); bus.FETCH = 1'b0;
        bus.DECODE = 1'b1; step(); bus.DECODE = 1'b0;
        bus.JMPX = 1'b1; bus.JRX = 1'b0; bus.CC_APPLYX = 1'b0; bus.JUMP_OPERAND = 16'h4444;
        bus.EXECUTE = 1'b1; step(); bus.EXECUTE = 1'b0; bus.JMPX = 1'b0;
        check_val("exe_taken", {31'h0, bus.TAKEN}, 32'h1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("mid_rst_pc",    {16'h0, bus.PC_OUT},  {16'h0, RV});
        check_val("mid_rst_taken", {31'h0, bus.TAKEN},   32'h0);
        check_val("mid_rst_err",   {31'h0, bus.SEQ_ERR}, 32'h0);
        step();
        rst_n = 1'b1;
        bus.COMMIT = 1'b1; step(); bus.COMMIT = 1'b0;
        check_val("mid_rst_nowen", {31'h0, bus.LINK_WEN}, 32'h0);
        check_val("mid_rst_nopc",  {16'h0, bus.PC_OUT},   {16'h0, RV});
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h0000, 1'b0);
        check_val("post_rst_pc", {16'h0, bus.PC_OUT}, 32'h0102);

        // LINK_WEN must fall with the asynchronous reset
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h0800, 1'b1);
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
